// File: rtl/alu_arbiter_if.sv
// Purpose: bundles the requester, ALU and response signals of the shared-ALU arbiter.
// Latency: none, wiring only.
// Backpressure: request side is valid/ready; responses are always accepted.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 4
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*CTRL_W-1:0] req_ctrl_i;
    logic [NUM_REQ-1:0]        req_invert_i;
    logic [NUM_REQ*XLEN-1:0]   req_a_i;
    logic [NUM_REQ*XLEN-1:0]   req_b_i;
    logic                      flush_i;
    logic                      alu_valid_o;
    logic [CTRL_W-1:0]         alu_ctrl_o;
    logic [XLEN-1:0]           alu_a_o;
    logic [XLEN-1:0]           alu_b_o;
    logic [XLEN-1:0]           alu_result_i;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [XLEN-1:0]           rsp_result_o;
    logic                      rsp_cond_o;

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_ctrl_i, req_invert_i, req_a_i, req_b_i, flush_i, alu_result_i,
        output req_ready_o, alu_valid_o, alu_ctrl_o, alu_a_o, alu_b_o,
        output rsp_valid_o, rsp_result_o, rsp_cond_o
    );

    // Requesters plus ALU side.
    modport master (
        output req_valid_i, req_ctrl_i, req_invert_i, req_a_i, req_b_i, flush_i, alu_result_i,
        input  req_ready_o, alu_valid_o, alu_ctrl_o, alu_a_o, alu_b_o,
        input  rsp_valid_o, rsp_result_o, rsp_cond_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose: round-robin share of one pipelined ALU among NUM_REQ requesters, tagged result return.
// Latency: grant at T, ALU issue at T+1, response at T+1+ALU_LATENCY.
// Backpressure: req_ready_o withheld while a requester has an op in flight or flush_i is high.
module alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int XLEN        = 32,
    parameter int CTRL_W      = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    alu_arbiter_if.slave  bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           inv;
    } tag_t;

    logic [NUM_REQ-1:0] outstanding;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_clr;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     grant_id;
    logic               grant_vld;

    logic               iss_vld;
    logic [IDW-1:0]     iss_id;
    logic               iss_inv;
    logic [CTRL_W-1:0]  iss_ctrl;
    logic [XLEN-1:0]    iss_a;
    logic [XLEN-1:0]    iss_b;

    tag_t               tag_pipe [ALU_LATENCY];
    tag_t               tail;
    logic               rsp_fire;

    // Index base+off modulo NUM_REQ without relying on a power-of-two count.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    assign eligible = bus.req_valid_i & ~outstanding;
    assign tail     = tag_pipe[ALU_LATENCY-1];
    // A response landing in a flush cycle is dropped along with everything else in flight.
    assign rsp_fire = tail.vld & ~bus.flush_i;
    assign rsp_clr  = rsp_fire ? (NUM_REQ'(1) << tail.id) : '0;

    // Round-robin pick: first eligible requester scanning upward from ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && eligible[wrap_idx(ptr, k)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_idx(ptr, k);
            end
        end
        // Reset gating keeps every output low while rst_ni is asserted.
        if (bus.flush_i || !rst_ni) grant_vld = 1'b0;
        grant = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
    end

    // Pointer and per-requester in-flight bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr         <= '0;
            outstanding <= '0;
        end else if (bus.flush_i) begin
            outstanding <= '0;
        end else begin
            // Clear takes effect next cycle, so a requester cannot be regranted in its own response cycle.
            outstanding <= (outstanding & ~rsp_clr) | grant;
            if (grant_vld) ptr <= wrap_idx(grant_id, 1);
        end
    end

    // Issue registers feeding the ALU; idle cycles drive control 0, operands hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_vld  <= 1'b0;
            iss_id   <= '0;
            iss_inv  <= 1'b0;
            iss_ctrl <= '0;
            iss_a    <= '0;
            iss_b    <= '0;
        end else begin
            iss_vld <= grant_vld;
            iss_id  <= grant_id;
            iss_inv <= bus.req_invert_i[grant_id];
            if (grant_vld) begin
                iss_ctrl <= bus.req_ctrl_i[int'(grant_id)*CTRL_W +: CTRL_W];
                iss_a    <= bus.req_a_i[int'(grant_id)*XLEN +: XLEN];
                iss_b    <= bus.req_b_i[int'(grant_id)*XLEN +: XLEN];
            end else begin
                iss_ctrl <= '0;
            end
        end
    end

    // Tag shift register tracking the ALU pipeline; its tail lines up with alu_result_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < ALU_LATENCY; k++) tag_pipe[k] <= '0;
        end else if (bus.flush_i) begin
            for (int k = 0; k < ALU_LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{vld: iss_vld, id: iss_id, inv: iss_inv};
            for (int k = 1; k < ALU_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign bus.req_ready_o  = grant;
    assign bus.alu_valid_o  = iss_vld;
    assign bus.alu_ctrl_o   = iss_ctrl;
    assign bus.alu_a_o      = iss_a;
    assign bus.alu_b_o      = iss_b;
    assign bus.rsp_valid_o  = rsp_clr;
    assign bus.rsp_result_o = rsp_fire ? bus.alu_result_i : '0;
    assign bus.rsp_cond_o   = rsp_fire & (bus.alu_result_i[0] ^ tail.inv);
endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: directed self-checking bench for alu_arbiter with a 2-stage ALU model.
// Latency: inputs driven on falling edge, outputs sampled 1 time unit later.
// Backpressure: requesters hold valid per step; responses always taken.
module tb_alu_arbiter;
    localparam logic [3:0] ALU_A = 4'd0;
    localparam logic [3:0] ADD   = 4'd1;
    localparam logic [3:0] SUB   = 4'd2;
    localparam logic [3:0] EQUAL = 4'd3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_arbiter_if #(.NUM_REQ(4), .XLEN(32), .CTRL_W(4)) bus ();

    alu_arbiter #(.NUM_REQ(4), .XLEN(32), .CTRL_W(4), .ALU_LATENCY(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage ALU model.
    logic [3:0]  s1_c, s2_c;
    logic [31:0] s1_a, s1_b, s2_a, s2_b;

    function automatic logic [31:0] alu_eval(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_A:   return a;
            ADD:     return a + b;
            SUB:     return a - b;
            EQUAL:   return {31'b0, a == b};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_c <= '0; s1_a <= '0; s1_b <= '0;
            s2_c <= '0; s2_a <= '0; s2_b <= '0;
        end else begin
            s1_c <= bus.alu_ctrl_o; s1_a <= bus.alu_a_o; s1_b <= bus.alu_b_o;
            s2_c <= s1_c; s2_a <= s1_a; s2_b <= s1_b;
        end
    end

    assign bus.alu_result_i = alu_eval(s2_c, s2_a, s2_b);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic inv,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_ctrl_i[i*4 +: 4]   = c;
        bus.req_invert_i[i]        = inv;
        bus.req_a_i[i*32 +: 32]    = a;
        bus.req_b_i[i*32 +: 32]    = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.req_valid_i  = '0;
        bus.req_ctrl_i   = '0;
        bus.req_invert_i = '0;
        bus.req_a_i      = '0;
        bus.req_b_i      = '0;
        bus.flush_i      = 1'b0;

        // Reset state, with requests pending to show ready is held low.
        @(negedge clk);
        bus.req_valid_i = 4'b1111;
        #1;
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_alu_valid", bus.alu_valid_o, 0);
        chk("rst_alu_ctrl", bus.alu_ctrl_o, 0);
        chk("rst_alu_a", bus.alu_a_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_result", bus.rsp_result_o, 0);
        chk("rst_rsp_cond", bus.rsp_cond_o, 0);
        bus.req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADD from requester 0.
        @(negedge clk);
        set_req(0, ADD, 1'b0, 32'd5, 32'd7);
        bus.req_valid_i = 4'b0001;
        #1;
        chk("single_ready", bus.req_ready_o, 4'b0001);
        chk("single_alu_valid_T", bus.alu_valid_o, 0);
        @(negedge clk);
        bus.req_valid_i = '0;
        #1;
        chk("single_alu_valid_T1", bus.alu_valid_o, 1);
        chk("single_alu_ctrl", bus.alu_ctrl_o, ADD);
        chk("single_alu_a", bus.alu_a_o, 5);
        chk("single_alu_b", bus.alu_b_o, 7);
        chk("single_rsp_T1", bus.rsp_valid_o, 0);
        @(negedge clk); #1;
        chk("single_idle_valid", bus.alu_valid_o, 0);
        chk("single_idle_ctrl", bus.alu_ctrl_o, ALU_A);
        chk("single_hold_a", bus.alu_a_o, 5);
        chk("single_rsp_T2", bus.rsp_valid_o, 0);
        @(negedge clk); #1;
        chk("single_rsp_T3", bus.rsp_valid_o, 4'b0001);
        chk("single_result", bus.rsp_result_o, 12);
        chk("single_cond", bus.rsp_cond_o, 0);
        @(negedge clk); #1;
        chk("single_rsp_T4", bus.rsp_valid_o, 0);

        // All four requesting continuously from a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, ADD, 1'b0, 32'(i * 10), 32'd1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            bus.req_valid_i = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("rr_ready_%0d", k), bus.req_ready_o, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
            if (k >= 3) begin
                chk($sformatf("rr_rsp_%0d", k), bus.rsp_valid_o, 4'b0001 << ((k - 3) % 4));
                chk($sformatf("rr_result_%0d", k), bus.rsp_result_o, ((k - 3) % 4) * 10 + 1);
            end else begin
                chk($sformatf("rr_rsp_%0d", k), bus.rsp_valid_o, 0);
            end
        end
        @(negedge clk);

        // Branch condition: EQUAL with invert on requester 2.
        @(negedge clk);
        set_req(2, EQUAL, 1'b1, 32'd3, 32'd3);
        bus.req_valid_i = 4'b0100;
        #1;
        chk("br_eq_ready", bus.req_ready_o, 4'b0100);
        @(negedge clk);
        bus.req_valid_i = '0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("br_eq_rsp", bus.rsp_valid_o, 4'b0100);
        chk("br_eq_result", bus.rsp_result_o, 1);
        chk("br_eq_cond", bus.rsp_cond_o, 0);
        @(negedge clk);
        set_req(2, EQUAL, 1'b1, 32'd3, 32'd4);
        bus.req_valid_i = 4'b0100;
        #1;
        chk("br_ne_ready", bus.req_ready_o, 4'b0100);
        @(negedge clk);
        bus.req_valid_i = '0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("br_ne_rsp", bus.rsp_valid_o, 4'b0100);
        chk("br_ne_result", bus.rsp_result_o, 0);
        chk("br_ne_cond", bus.rsp_cond_o, 1);

        // ptr=3: grant 1 moves ptr to 2, then requesters 0 and 3 compete.
        @(negedge clk);
        bus.req_valid_i = 4'b0010;
        #1;
        chk("ptr_setup_ready", bus.req_ready_o, 4'b0010);
        @(negedge clk);
        bus.req_valid_i = 4'b1001;
        #1;
        chk("ptr2_grant3", bus.req_ready_o, 4'b1000);
        @(negedge clk); #1;
        chk("ptr0_grant0", bus.req_ready_o, 4'b0001);
        @(negedge clk);
        bus.req_valid_i = '0;
        idle(4);

        // Flush one cycle after issuing requester 1.
        set_req(1, ADD, 1'b0, 32'd20, 32'd22);
        bus.req_valid_i = 4'b0010;
        #1;
        chk("fl_ready_T", bus.req_ready_o, 4'b0010);
        @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("fl_ready_flush", bus.req_ready_o, 0);
        chk("fl_alu_valid_T1", bus.alu_valid_o, 1);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk("fl_regrant", bus.req_ready_o, 4'b0010);
        chk("fl_alu_valid_T2", bus.alu_valid_o, 0);
        @(negedge clk);
        bus.req_valid_i = '0;
        #1;
        chk("fl_no_rsp_T3", bus.rsp_valid_o, 0);
        chk("fl_reissue_valid", bus.alu_valid_o, 1);
        @(negedge clk); #1;
        chk("fl_no_rsp_T4", bus.rsp_valid_o, 0);
        @(negedge clk); #1;
        chk("fl_reissue_rsp", bus.rsp_valid_o, 4'b0010);
        chk("fl_reissue_result", bus.rsp_result_o, 42);

        // Flush in the very cycle a response would land.
        @(negedge clk);
        set_req(0, ADD, 1'b0, 32'd1, 32'd1);
        bus.req_valid_i = 4'b0001;
        #1;
        chk("fl2_ready", bus.req_ready_o, 4'b0001);
        @(negedge clk);
        bus.req_valid_i = '0;
        @(negedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("fl2_rsp_suppressed", bus.rsp_valid_o, 0);
        chk("fl2_result_zero", bus.rsp_result_o, 0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk("fl2_rsp_after", bus.rsp_valid_o, 0);

        // Reset with two ops in flight (ptr=1 here).
        @(negedge clk);
        set_req(0, ADD, 1'b0, 32'd2, 32'd2);
        set_req(1, ADD, 1'b0, 32'd3, 32'd3);
        bus.req_valid_i = 4'b0011;
        #1;
        chk("mr_grant1", bus.req_ready_o, 4'b0010);
        @(negedge clk); #1;
        chk("mr_grant0", bus.req_ready_o, 4'b0001);
        @(negedge clk); #1;
        chk("mr_alu_valid", bus.alu_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_ready", bus.req_ready_o, 0);
        chk("mr_alu_valid_rst", bus.alu_valid_o, 0);
        chk("mr_alu_a_rst", bus.alu_a_o, 0);
        chk("mr_rsp_rst", bus.rsp_valid_o, 0);
        bus.req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("mr_no_rsp_%0d", k), bus.rsp_valid_o, 0);
            chk($sformatf("mr_no_issue_%0d", k), bus.alu_valid_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
